// File: rtl/sip_shift_acc.sv
// Shift-and-accumulate stage for a bit-serial SIP datapath: sums shifted signed
// partial sums into saturating group results behind a one-entry output register.
module sip_shift_acc #(
  parameter int P_IN_W  = 10,
  parameter int P_ACC_W = 24,
  parameter int P_SH_W  = 3
) (
  input  logic               i_CLK,
  input  logic               i_RSTn,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [P_IN_W-1:0]  i_psum,
  input  logic [P_SH_W-1:0]  i_shift,
  input  logic               i_last,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [P_ACC_W-1:0] o_acc,
  output logic               o_ovf,
  output logic [7:0]         o_beats
);

  typedef enum logic {S_IDLE, S_ACC} state_t;

  localparam logic [P_ACC_W-1:0] ACC_MAX = {1'b0, {(P_ACC_W-1){1'b1}}};
  localparam logic [P_ACC_W-1:0] ACC_MIN = {1'b1, {(P_ACC_W-1){1'b0}}};

  state_t             state;
  logic [P_ACC_W-1:0] acc;
  logic               ovf;
  logic [7:0]         cnt;

  logic               beat_acc;
  logic               take;
  logic [P_ACC_W-1:0] psum_sh;
  logic [P_ACC_W-1:0] acc_base;
  logic [P_ACC_W:0]   sum_wide;
  logic [P_ACC_W-1:0] sum_sat;
  logic               clip;
  logic [7:0]         cnt_base;
  logic [7:0]         cnt_next;
  logic               ovf_next;

  assign o_ready  = ~o_valid | i_ready;
  assign beat_acc = i_valid & o_ready;
  assign take     = o_valid & i_ready;

  // NOTE: every signal written here gets a value on every path first, so no latch is inferred.
  always_comb begin
    psum_sh  = {{(P_ACC_W-P_IN_W){i_psum[P_IN_W-1]}}, i_psum} << i_shift;
    acc_base = (state == S_IDLE) ? '0 : acc;
    cnt_base = (state == S_IDLE) ? 8'd0 : cnt;
    sum_wide = {acc_base[P_ACC_W-1], acc_base} + {psum_sh[P_ACC_W-1], psum_sh};
    // The two top bits disagree exactly when the signed add left the P_ACC_W range.
    clip     = sum_wide[P_ACC_W] ^ sum_wide[P_ACC_W-1];
    sum_sat  = sum_wide[P_ACC_W-1:0];
    if (clip) sum_sat = sum_wide[P_ACC_W] ? ACC_MIN : ACC_MAX;
    cnt_next = (cnt_base == 8'd255) ? 8'd255 : cnt_base + 8'd1;
    ovf_next = ((state == S_IDLE) ? 1'b0 : ovf) | clip;
  end

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_CLK) begin
    if (!i_RSTn) begin
      state   <= S_IDLE;
      acc     <= '0;
      ovf     <= 1'b0;
      cnt     <= 8'd0;
      o_valid <= 1'b0;
      o_acc   <= '0;
      o_ovf   <= 1'b0;
      o_beats <= 8'd0;
    end else begin
      if (take) o_valid <= 1'b0;
      if (beat_acc) begin
        if (i_last) begin
          // A same-cycle take is overridden here, giving back-to-back results without a bubble.
          o_valid <= 1'b1;
          o_acc   <= sum_sat;
          o_ovf   <= ovf_next;
          o_beats <= cnt_next;
          acc     <= '0;
          ovf     <= 1'b0;
          cnt     <= 8'd0;
          state   <= S_IDLE;
        end else begin
          acc     <= sum_sat;
          ovf     <= ovf_next;
          cnt     <= cnt_next;
          state   <= S_ACC;
        end
      end
    end
  end

endmodule

// File: tb/tb_sip_shift_acc.sv
// Scoreboard bench for sip_shift_acc: directed groups push expected results,
// an independent monitor pops and compares on every output handshake.
module tb_sip_shift_acc;

  localparam int IN_W  = 10;
  localparam int ACC_W = 24;
  localparam int SH_W  = 3;

  typedef struct packed {
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [7:0]       beats;
  } res_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_valid;
  logic             o_ready;
  logic [IN_W-1:0]  i_psum;
  logic [SH_W-1:0]  i_shift;
  logic             i_last;
  logic             o_valid;
  logic             i_ready;
  logic [ACC_W-1:0] o_acc;
  logic             o_ovf;
  logic [7:0]       o_beats;

  int   n_tests = 0;
  int   n_fail  = 0;
  res_t exp_q[$];

  sip_shift_acc #(.P_IN_W(IN_W), .P_ACC_W(ACC_W), .P_SH_W(SH_W)) dut (
    .i_CLK   (clk),
    .i_RSTn  (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_psum  (i_psum),
    .i_shift (i_shift),
    .i_last  (i_last),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_acc   (o_acc),
    .o_ovf   (o_ovf),
    .o_beats (o_beats)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    end
  endtask

  function automatic void push_exp(input int acc, input bit ovf, input int beats);
    res_t r;
    r.acc   = ACC_W'(acc);
    r.ovf   = ovf;
    r.beats = 8'(beats);
    exp_q.push_back(r);
  endfunction

  // Monitor: the handshake seen at a negedge is the one the next rising edge commits.
  always @(negedge clk) begin
    if (rst_n && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got acc 'h%0h with empty scoreboard", o_acc);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check("result_acc", 32'(o_acc), 32'(e.acc));
        check("result_ovf", 32'(o_ovf), 32'(e.ovf));
        check("result_beats", 32'(o_beats), 32'(e.beats));
      end
    end
  end

  // Presents one beat and returns 1 time unit after the edge that accepted it.
  task automatic beat(input int psum, input int sh, input bit last);
    int waits = 0;
    bit ok;
    i_valid = 1'b1;
    i_psum  = IN_W'(psum);
    i_shift = SH_W'(sh);
    i_last  = last;
    forever begin
      @(negedge clk);
      ok = o_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      waits++;
      if (waits > 200) begin
        n_tests++;
        n_fail++;
        $display("FAIL beat_timeout: beat %0d not accepted after %0d cycles", psum, waits);
        break;
      end
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    i_valid = 1'b0;
    exp_q.delete();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_o_acc", 32'(o_acc), 32'd0);
    check("rst_o_ovf", 32'(o_ovf), 32'd0);
    check("rst_o_beats", 32'(o_beats), 32'd0);
    check("rst_o_ready", 32'(o_ready), 32'd1);
  endtask

  initial begin
    int wait_cycles;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_psum  = '0;
    i_shift = '0;
    i_last  = 1'b0;
    i_ready = 1'b1;
    do_reset();

    // 3 + (-2<<2) + (5<<1) = 5, visible one cycle after the last beat
    push_exp(5, 1'b0, 3);
    beat(3, 0, 1'b0);
    beat(-2, 2, 1'b0);
    beat(5, 1, 1'b1);
    check("latency_o_valid", 32'(o_valid), 32'd1);
    idle(2);

    // Same group with i_valid gaps
    push_exp(5, 1'b0, 3);
    beat(3, 0, 1'b0);
    idle(3);
    beat(-2, 2, 1'b0);
    idle(1);
    beat(5, 1, 1'b1);
    idle(2);

    // Positive saturation: 200 x (511<<7) exceeds 2^23-1
    push_exp(8388607, 1'b1, 200);
    for (int i = 1; i <= 200; i++) beat(511, 7, i == 200);
    idle(2);

    // Negative saturation: 128 x (-512<<7) hits -2^23 exactly, beats 129..130 clip
    push_exp(-8388608, 1'b1, 130);
    for (int i = 1; i <= 130; i++) beat(-512, 7, i == 130);
    idle(2);

    // Beat count saturates at 255 while the sum keeps going
    push_exp(300, 1'b0, 255);
    for (int i = 1; i <= 300; i++) beat(1, 0, i == 300);
    idle(2);

    // Back-to-back single-beat groups, no bubble
    push_exp(-512, 1'b0, 1);
    push_exp(511, 1'b0, 1);
    beat(-512, 0, 1'b1);
    check("b2b_first_valid", 32'(o_valid), 32'd1);
    check("b2b_first_acc", 32'(o_acc), 32'hFFFE00);
    beat(511, 0, 1'b1);
    check("b2b_second_valid", 32'(o_valid), 32'd1);
    check("b2b_second_acc", 32'(o_acc), 32'd511);
    idle(2);

    // Output stall: first result held, second last beat blocked until i_ready rises
    i_ready = 1'b0;
    push_exp(3, 1'b0, 2);
    push_exp(20, 1'b0, 1);
    beat(1, 0, 1'b0);
    beat(2, 0, 1'b1);
    fork
      beat(10, 1, 1'b1);
      begin
        repeat (3) begin
          @(negedge clk);
          check("stall_o_ready", 32'(o_ready), 32'd0);
          check("stall_hold_acc", 32'(o_acc), 32'd3);
          check("stall_hold_beats", 32'(o_beats), 32'd2);
        end
        @(posedge clk);
        #1;
        i_ready = 1'b1;
      end
    join
    idle(3);

    // Reset after 2 of 4 beats discards the open group
    beat(1, 0, 1'b0);
    beat(1, 0, 1'b0);
    do_reset();
    push_exp(7, 1'b0, 1);
    beat(7, 0, 1'b1);
    idle(2);

    // Reset discards a pending unread result
    i_ready = 1'b0;
    beat(9, 0, 1'b1);
    check("pending_valid", 32'(o_valid), 32'd1);
    do_reset();
    i_ready = 1'b1;
    @(negedge clk);
    check("pending_dropped", 32'(o_valid), 32'd0);
    idle(2);

    wait_cycles = 0;
    while (exp_q.size() != 0 && wait_cycles < 50) begin
      @(posedge clk);
      wait_cycles++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
